// File: rtl/range_chunk_streamer.sv
// Range chunk streamer: collects (lo,hi) tuples LANES per beat into per-lane banks,
// then drains them as fixed CHUNK-tuple blocks padded with all-ones sentinels.
module range_chunk_streamer #(
   parameter int ELEM_W = 64,
   parameter int LANES  = 2,
   parameter int DEPTH  = 512,
   parameter int CHUNK  = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          wr_valid_in,
   input  logic [$clog2(LANES+1)-1:0]    wr_lanes_in,
   input  logic [LANES*2*ELEM_W-1:0]     wr_data_in,
   output logic                          wr_ready_out,
   input  logic                          stream_done_in,
   output logic                          chunk_valid_out,
   input  logic                          chunk_ready_in,
   output logic [CHUNK*2*ELEM_W-1:0]     chunk_flat_out,
   output logic [$clog2(CHUNK+1)-1:0]    chunk_count_out,
   output logic                          chunk_last_out,
   output logic                          drain_done_out,
   output logic                          overflow_out,
   output logic                          busy_out
);
   localparam int TW  = 2*ELEM_W;
   localparam int CAP = DEPTH*LANES;
   localparam int R   = CHUNK/LANES;
   localparam int CW  = $clog2(CAP+1);
   localparam int KW  = $clog2(CHUNK+1);
   localparam int RW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW  = $clog2(R+1);
   localparam int SW  = (R > 1) ? $clog2(R) : 1;

   localparam logic [1:0] FILL     = 2'd0;
   localparam logic [1:0] DRAIN_RD = 2'd1;
   localparam logic [1:0] PRESENT  = 2'd2;
   localparam logic [1:0] FINISH   = 2'd3;

   logic [1:0]               state;
   logic [CW-1:0]            count;
   logic [CW-1:0]            chunk_base;
   logic [NW-1:0]            rd_cnt;
   logic                     rd_vld_q;
   logic [SW-1:0]            rd_slot_q;
   logic [CHUNK*TW-1:0]      chunk_flat_q;
   logic                     overflow_q;

   logic                     full;
   logic                     lanes_ok;
   logic                     wr_fire;
   logic [CW-1:0]            count_fill;
   logic [CW-1:0]            remaining;
   logic                     is_last;
   logic [RW-1:0]            rd_row;
   logic [LANES*TW-1:0]      rd_flat;
   logic [LANES-1:0]         bank_we;
   logic [LANES-1:0][RW-1:0] bank_row;
   logic [LANES-1:0][TW-1:0] bank_wdata;
   int                       space;
   int                       n_add;
   int                       lane_off;
   int                       tup_addr;

   // Beat lane j lands at tuple address count+j, so each bank picks the beat lane
   // that rotates onto it; a beat may straddle two rows. Writes never pass capacity.
   always_comb begin
      full       = (count == CW'(CAP));
      lanes_ok   = (wr_lanes_in != '0) && (int'(wr_lanes_in) <= LANES);
      wr_fire    = (state == FILL) && wr_valid_in && !full && lanes_ok;
      space      = CAP - int'(count);
      n_add      = (int'(wr_lanes_in) < space) ? int'(wr_lanes_in) : space;
      count_fill = wr_fire ? count + CW'(n_add) : count;
      bank_we    = '0;
      bank_row   = '0;
      bank_wdata = '0;
      lane_off   = 0;
      tup_addr   = 0;
      for (int l = 0; l < LANES; l++) begin
         lane_off      = (l + LANES - (int'(count) % LANES)) % LANES;
         tup_addr      = int'(count) + lane_off;
         bank_row[l]   = RW'(tup_addr / LANES);
         bank_wdata[l] = wr_data_in[lane_off*TW +: TW];
         bank_we[l]    = wr_fire && (lane_off < n_add);
      end
   end

   assign rd_row = RW'(int'(chunk_base) / LANES + int'(rd_cnt));

   for (genvar g = 0; g < LANES; g++) begin : g_bank
      logic [TW-1:0] mem [DEPTH];
      logic [TW-1:0] rd_q;
      always_ff @(posedge clock) begin
         if (bank_we[g]) mem[bank_row[g]] <= bank_wdata[g];
         rd_q <= mem[rd_row];
      end
      assign rd_flat[g*TW +: TW] = rd_q;
   end

   always_comb begin
      remaining       = count - chunk_base;
      is_last         = (remaining <= CW'(CHUNK));
      chunk_valid_out = (state == PRESENT);
      chunk_last_out  = chunk_valid_out && is_last;
      chunk_count_out = '0;
      if (chunk_valid_out) chunk_count_out = is_last ? KW'(remaining) : KW'(CHUNK);
      chunk_flat_out  = chunk_flat_q;
      wr_ready_out    = reset_n && (state == FILL) && !full;
      drain_done_out  = (state == FINISH);
      overflow_out    = overflow_q;
      busy_out        = (state != FILL);
   end

   // DRAIN_RD issues R row reads, then spends one more cycle landing the last row.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= FILL;
         count        <= '0;
         chunk_base   <= '0;
         rd_cnt       <= '0;
         rd_vld_q     <= 1'b0;
         rd_slot_q    <= '0;
         chunk_flat_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         rd_vld_q <= 1'b0;
         if (rd_vld_q) begin
            for (int l = 0; l < LANES; l++) begin
               if (int'(chunk_base) + int'(rd_slot_q)*LANES + l < int'(count))
                  chunk_flat_q[(int'(rd_slot_q)*LANES + l)*TW +: TW] <= rd_flat[l*TW +: TW];
               else
                  chunk_flat_q[(int'(rd_slot_q)*LANES + l)*TW +: TW] <= {TW{1'b1}};
            end
         end
         case (state)
            FILL: begin
               count <= count_fill;
               if (wr_valid_in && full) overflow_q <= 1'b1;
               if (stream_done_in) begin
                  chunk_base <= '0;
                  rd_cnt     <= '0;
                  state      <= (count_fill == '0) ? FINISH : DRAIN_RD;
               end
            end
            DRAIN_RD: begin
               if (rd_cnt == NW'(R)) begin
                  state <= PRESENT;
               end else begin
                  rd_vld_q  <= 1'b1;
                  rd_slot_q <= SW'(rd_cnt);
                  rd_cnt    <= rd_cnt + 1'b1;
               end
            end
            PRESENT: begin
               if (chunk_ready_in) begin
                  if (is_last) begin
                     state <= FINISH;
                  end else begin
                     chunk_base <= chunk_base + CW'(CHUNK);
                     rd_cnt     <= '0;
                     state      <= DRAIN_RD;
                  end
               end
            end
            default: begin
               count      <= '0;
               chunk_base <= '0;
               overflow_q <= 1'b0;
               state      <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_range_chunk_streamer.sv
// Self-checking bench for range_chunk_streamer: a tuple-queue model predicts every
// chunk, a negedge monitor compares presented chunks, and directed/random phases run it.
module tb_range_chunk_streamer;
   localparam int ELEM_W = 64;
   localparam int LANES  = 2;
   localparam int DEPTH  = 512;
   localparam int CHUNK  = 16;
   localparam int TW     = 2*ELEM_W;
   localparam int CAP    = DEPTH*LANES;
   localparam int R      = CHUNK/LANES;
   localparam int LW     = $clog2(LANES+1);
   localparam int KW     = $clog2(CHUNK+1);

   typedef struct {
      logic [CHUNK*TW-1:0] flat;
      int                  count;
      bit                  last;
   } chunk_t;

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic                wr_valid_in = 1'b0;
   logic [LW-1:0]       wr_lanes_in = '0;
   logic [LANES*TW-1:0] wr_data_in = '0;
   logic                wr_ready_out;
   logic                stream_done_in = 1'b0;
   logic                chunk_valid_out;
   logic                chunk_ready_in = 1'b0;
   logic [CHUNK*TW-1:0] chunk_flat_out;
   logic [KW-1:0]       chunk_count_out;
   logic                chunk_last_out;
   logic                drain_done_out;
   logic                overflow_out;
   logic                busy_out;

   int                  compared = 0;
   int                  mismatched = 0;
   bit                  m_overflow = 1'b0;
   logic [TW-1:0]       model_q[$];
   chunk_t              exp_q[$];

   logic [CHUNK*TW-1:0] f_flat;
   int                  f_count;
   bit                  f_last;
   logic [LANES*TW-1:0] beat;

   always #5 clock = ~clock;

   range_chunk_streamer #(.ELEM_W(ELEM_W), .LANES(LANES), .DEPTH(DEPTH), .CHUNK(CHUNK)) dut (
      .clock(clock), .reset_n(reset_n),
      .wr_valid_in(wr_valid_in), .wr_lanes_in(wr_lanes_in), .wr_data_in(wr_data_in),
      .wr_ready_out(wr_ready_out), .stream_done_in(stream_done_in),
      .chunk_valid_out(chunk_valid_out), .chunk_ready_in(chunk_ready_in),
      .chunk_flat_out(chunk_flat_out), .chunk_count_out(chunk_count_out),
      .chunk_last_out(chunk_last_out), .drain_done_out(drain_done_out),
      .overflow_out(overflow_out), .busy_out(busy_out)
   );

   task automatic checkOutput(input string name, input longint act, input longint exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkTuple(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkFlat(input string name, input logic [CHUNK*TW-1:0] act,
                            input logic [CHUNK*TW-1:0] exp);
      bit shown;
      shown = 1'b0;
      compared++;
      if (act !== exp) begin
         mismatched++;
         for (int k = 0; k < CHUNK; k++) begin
            if (!shown && act[k*TW +: TW] !== exp[k*TW +: TW]) begin
               $display("[TB] FAIL %s slot %0d: got %h, expected %h",
                        name, k, act[k*TW +: TW], exp[k*TW +: TW]);
               shown = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [TW-1:0] pairTuple(input int i);
      return {ELEM_W'(i), ELEM_W'(i + 100)};
   endfunction

   function automatic logic [TW-1:0] randTuple();
      logic [TW-1:0] t;
      for (int w = 0; w < TW/32; w++) t[w*32 +: 32] = $urandom;
      return t;
   endfunction

   // Slice the accepted tuple stream into CHUNK blocks, sentinel-padding the tail.
   task automatic buildChunks();
      int     n;
      chunk_t c;
      n = model_q.size();
      for (int base = 0; base < n; base += CHUNK) begin
         for (int k = 0; k < CHUNK; k++)
            c.flat[k*TW +: TW] = (base + k < n) ? model_q[base + k] : {TW{1'b1}};
         c.count = (n - base < CHUNK) ? n - base : CHUNK;
         c.last  = (n - base <= CHUNK);
         exp_q.push_back(c);
      end
      model_q.delete();
   endtask

   task automatic applyStimulus(input bit valid, input int n, input logic [LANES*TW-1:0] data,
                                input bit done);
      checkOutput("wr_ready", wr_ready_out, model_q.size() < CAP);
      wr_valid_in    = valid;
      wr_lanes_in    = LW'(n);
      wr_data_in     = data;
      stream_done_in = done;
      @(posedge clock); #1;
      if (valid) begin
         if (model_q.size() >= CAP) m_overflow = 1'b1;
         else if (n >= 1 && n <= LANES)
            for (int i = 0; i < n; i++)
               if (model_q.size() < CAP) model_q.push_back(data[i*TW +: TW]);
      end
      wr_valid_in    = 1'b0;
      wr_lanes_in    = '0;
      stream_done_in = 1'b0;
      checkOutput("overflow", overflow_out, m_overflow);
      if (done) buildChunks();
   endtask

   // Called in the cycle right after the done edge; delay<0 means random ready delay.
   task automatic waitDrain(input int delay, output logic [CHUNK*TW-1:0] ff,
                            output int fc, output bit fl);
      int k, expect_valid, hs_k, wait_left, chunks, n_exp;
      bit presenting, seen_done;
      k = 0; expect_valid = R + 1; hs_k = -1; wait_left = 0; chunks = 0;
      presenting = 1'b0; seen_done = 1'b0; n_exp = exp_q.size();
      ff = '0; fc = -1; fl = 1'b0;
      checkOutput("busy_in_drain", busy_out, 1);
      while (k < 2000) begin
         if (drain_done_out) begin
            checkOutput("drain_done_time", k, (n_exp == 0) ? 0 : hs_k + 1);
            seen_done = 1'b1;
            break;
         end
         if (chunk_valid_out && !presenting) begin
            checkOutput("chunk_latency", k, expect_valid);
            if (chunks == 0) begin
               ff = chunk_flat_out; fc = int'(chunk_count_out); fl = chunk_last_out;
            end
            chunks++;
            presenting = 1'b1;
            wait_left  = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
         end
         if (presenting) begin
            if (wait_left == 0) begin
               chunk_ready_in = 1'b1;
               presenting     = 1'b0;
               hs_k           = k;
               expect_valid   = k + R + 2;
            end else begin
               chunk_ready_in = 1'b0;
               wait_left--;
            end
         end else begin
            chunk_ready_in = 1'b0;
         end
         @(posedge clock); #1;
         k++;
      end
      chunk_ready_in = 1'b0;
      checkOutput("drain_done_seen", seen_done, 1);
      checkOutput("chunks_seen", chunks, n_exp);
      @(posedge clock); #1;
      m_overflow = 1'b0;
      checkOutput("drain_done_pulse", drain_done_out, 0);
      checkOutput("busy_after", busy_out, 0);
      checkOutput("overflow_cleared", overflow_out, m_overflow);
      checkOutput("ready_after", wr_ready_out, 1);
   endtask

   // Every presented cycle is compared, so a chunk that moves under backpressure fails.
   always @(negedge clock) begin
      if (reset_n && chunk_valid_out) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_chunk", exp_q.size(), 1);
         end else begin
            checkFlat("chunk_flat", chunk_flat_out, exp_q[0].flat);
            checkOutput("chunk_count", chunk_count_out, exp_q[0].count);
            checkOutput("chunk_last", chunk_last_out, exp_q[0].last);
            if (chunk_ready_in) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nb;
      bit dwl;

      #2;
      checkOutput("reset_ready", wr_ready_out, 0);
      checkOutput("reset_busy", busy_out, 0);
      checkOutput("reset_valid", chunk_valid_out, 0);
      checkOutput("reset_drain_done", drain_done_out, 0);
      checkOutput("reset_overflow", overflow_out, 0);
      #1 reset_n = 1'b1;
      #1;
      checkOutput("release_ready", wr_ready_out, 1);
      checkOutput("release_busy", busy_out, 0);
      @(posedge clock); #1;

      $display("[TB] exact chunk phase");
      for (int b = 0; b < 16; b++)
         applyStimulus(1'b1, 2, {pairTuple(2*b + 1), pairTuple(2*b)}, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1);
      waitDrain(0, f_flat, f_count, f_last);
      checkOutput("exact_count", f_count, 16);
      checkOutput("exact_first_last", f_last, 0);
      checkTuple("exact_slot0", f_flat[0 +: TW], {64'd0, 64'd100});
      checkTuple("exact_slot15", f_flat[15*TW +: TW], {64'd15, 64'd115});

      $display("[TB] partial and pad phase");
      applyStimulus(1'b1, 2, {pairTuple(1), pairTuple(0)}, 1'b0);
      applyStimulus(1'b1, 1, {randTuple(), pairTuple(2)}, 1'b0);
      applyStimulus(1'b1, 2, {pairTuple(4), pairTuple(3)}, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1);
      waitDrain(0, f_flat, f_count, f_last);
      checkOutput("partial_count", f_count, 5);
      checkOutput("partial_last", f_last, 1);
      checkTuple("partial_slot2", f_flat[2*TW +: TW], {64'd2, 64'd102});
      checkTuple("partial_slot4", f_flat[4*TW +: TW], {64'd4, 64'd104});
      checkTuple("partial_pad5", f_flat[5*TW +: TW], {TW{1'b1}});

      $display("[TB] backpressure phase");
      for (int b = 0; b < 10; b++) begin
         beat = {randTuple(), randTuple()};
         applyStimulus(1'b1, 2, beat, 1'b0);
      end
      applyStimulus(1'b0, 0, '0, 1'b1);
      waitDrain(20, f_flat, f_count, f_last);

      $display("[TB] done with final beat phase");
      for (int b = 0; b < 3; b++)
         applyStimulus(1'b1, 2, {pairTuple(2*b + 1), pairTuple(2*b)}, b == 2);
      waitDrain(0, f_flat, f_count, f_last);
      checkOutput("same_cycle_count", f_count, 6);

      $display("[TB] random phase");
      for (int round = 0; round < 5; round++) begin
         nb  = $urandom_range(1, 24);
         dwl = 1'($urandom_range(0, 1));
         for (int b = 0; b < nb; b++) begin
            beat = {randTuple(), randTuple()};
            applyStimulus($urandom_range(0, 4) != 0, int'($urandom_range(0, 3)), beat,
                          dwl && (b == nb - 1));
         end
         if (!dwl) applyStimulus(1'b0, 0, '0, 1'b1);
         waitDrain(-1, f_flat, f_count, f_last);
      end

      $display("[TB] full and overflow phase");
      for (int b = 0; b < CAP/LANES; b++)
         applyStimulus(1'b1, 2, {pairTuple(2*b + 1), pairTuple(2*b)}, 1'b0);
      applyStimulus(1'b1, 2, {randTuple(), randTuple()}, 1'b0);
      checkOutput("full_overflow", overflow_out, 1);
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("full_chunks_expected", exp_q.size(), CAP/CHUNK);
      waitDrain(0, f_flat, f_count, f_last);

      $display("[TB] reset during present phase");
      for (int b = 0; b < 2; b++)
         applyStimulus(1'b1, 2, {randTuple(), randTuple()}, b == 1);
      for (int k = 0; k < 50 && !chunk_valid_out; k++) begin
         @(posedge clock); #1;
      end
      checkOutput("present_reached", chunk_valid_out, 1);
      repeat (3) begin
         @(posedge clock); #1;
      end
      #1 reset_n = 1'b0;
      #1;
      checkOutput("midreset_valid", chunk_valid_out, 0);
      checkOutput("midreset_busy", busy_out, 0);
      checkOutput("midreset_ready", wr_ready_out, 0);
      checkFlat("midreset_flat", chunk_flat_out, '0);
      exp_q.delete();
      model_q.delete();
      m_overflow = 1'b0;
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("post_reset_busy", busy_out, 0);

      $display("[TB] empty stream phase");
      applyStimulus(1'b0, 0, '0, 1'b1);
      waitDrain(0, f_flat, f_count, f_last);
      checkOutput("empty_no_chunk", f_count, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
